parser_input_arbiter: RTL and testbench

- Shares the single packet input of the sequence parser between NUM_SRC packet sources.
- Grants are packet-atomic and round-robin. Once a source is granted, its beats pass through to the parser until its last beat is accepted.
- Keeps per-source accepted-packet counters.
- Flags a granted source that stalls mid-packet for too long.

---
 rtl/parser_input_arbiter.sv | 95 +++++++++
 tb/tb_parser_input_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parser_input_arbiter.sv
// parser_input_arbiter: packet-atomic round-robin arbiter onto the sequence parser input,
// with per-source completed-packet counters and a sticky mid-packet stall watchdog.
module parser_input_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int STALL_LIMIT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic [NUM_SRC*32-1:0]    src_data,
    input  logic [NUM_SRC-1:0]       src_val,
    input  logic [NUM_SRC-1:0]       src_last,
    output logic [NUM_SRC-1:0]       src_ready,
    output logic [31:0]              dataIn,
    output logic                     dataIn_val,
    output logic                     dataIN_last,
    input  logic                     dataIn_ready,
    output logic [2:0]               grant_id,
    output logic                     busy,
    output logic                     stall_err,
    input  logic                     clear_err,
    output logic [NUM_SRC*CNT_W-1:0] pkt_count
);
    localparam int SC_W = $clog2(STALL_LIMIT + 1);
    typedef enum logic {IDLE, BUSY} arbState;
    arbState state, nextState;
    logic [2:0] grant, lastGrant, winner;
    logic found, gVal, gLast, pktDone;
    logic [31:0] gData;
    logic [SC_W-1:0] stallCnt;
    logic [CNT_W-1:0] pktCnt [NUM_SRC];
    always_comb begin
        gData = '0;
        gVal = 1'b0;
        gLast = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant == 3'(i)) begin
                gData = src_data[32*i +: 32];
                gVal = src_val[i];
                gLast = src_last[i];
            end
        end
    end
    // first requester found searching upward from lastGrant+1, wrapping
    always_comb begin
        winner = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!found && src_val[i] && i == (int'(lastGrant) + k) % NUM_SRC) begin
                    winner = 3'(i);
                    found = 1'b1;
                end
            end
        end
    end
    always_comb begin
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) src_ready[i] = busy && grant == 3'(i) && dataIn_ready;
    end
    assign busy        = (state == BUSY);
    assign dataIn      = busy ? gData : '0;
    assign dataIn_val  = busy & gVal;
    assign dataIN_last = busy & gLast;
    assign grant_id    = grant;
    assign pktDone     = dataIn_val & dataIn_ready & dataIN_last;
    always_comb nextState = (state == IDLE) ? (found ? BUSY : IDLE) : (pktDone ? IDLE : BUSY);
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
            grant <= '0;
            lastGrant <= 3'(NUM_SRC - 1);
            stallCnt <= '0;
            stall_err <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) pktCnt[i] <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && found) grant <= winner;
            if (pktDone) lastGrant <= grant;
            for (int i = 0; i < NUM_SRC; i++) if (pktDone && grant == 3'(i)) pktCnt[i] <= pktCnt[i] + 1'b1;
            if (clear_err) begin
                stallCnt <= '0;
                stall_err <= 1'b0;
            end else if (!busy || gVal) begin
                stallCnt <= '0;
            end else if (stallCnt != SC_W'(STALL_LIMIT)) begin
                stallCnt <= stallCnt + 1'b1;
                if (stallCnt == SC_W'(STALL_LIMIT - 1)) stall_err <= 1'b1;
            end
        end
    end
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_cnt
        assign pkt_count[CNT_W*i +: CNT_W] = pktCnt[i];
    end
endmodule

// File: tb/tb_parser_input_arbiter.sv
// tb_parser_input_arbiter: randomized and directed stimulus against a packet-level reference
// model, plus a 2-source narrow-counter instance for counter wrap.
module tb_parser_input_arbiter;
    localparam int N = 4, LIM = 64, CW = 16;
    logic clk = 1'b0, reset_b = 1'b0;
    logic [N*32-1:0] srcData = '0;
    logic [N-1:0] srcVal = '0, srcLast = '0, srcReady;
    logic [31:0] dataIn;
    logic dataInVal, dataInLast, dataInReady = 1'b1, clearErr = 1'b0, busy, stallErr;
    logic [2:0] grantId;
    logic [N*CW-1:0] pktCount;
    logic [63:0] src2Data = '0;
    logic [1:0] src2Val = '0, src2Last = '0, src2Ready;
    logic [31:0] d2In;
    logic d2Val, d2Last, busy2, err2;
    logic [2:0] grant2;
    logic [3:0] cnt2;

    parser_input_arbiter #(.NUM_SRC(N), .STALL_LIMIT(LIM), .CNT_W(CW)) dut (
        .clk(clk), .reset_b(reset_b), .src_data(srcData), .src_val(srcVal), .src_last(srcLast),
        .src_ready(srcReady), .dataIn(dataIn), .dataIn_val(dataInVal), .dataIN_last(dataInLast),
        .dataIn_ready(dataInReady), .grant_id(grantId), .busy(busy), .stall_err(stallErr),
        .clear_err(clearErr), .pkt_count(pktCount));
    parser_input_arbiter #(.NUM_SRC(2), .STALL_LIMIT(LIM), .CNT_W(2)) dut2 (
        .clk(clk), .reset_b(reset_b), .src_data(src2Data), .src_val(src2Val), .src_last(src2Last),
        .src_ready(src2Ready), .dataIn(d2In), .dataIn_val(d2Val), .dataIN_last(d2Last),
        .dataIn_ready(1'b1), .grant_id(grant2), .busy(busy2), .stall_err(err2),
        .clear_err(1'b0), .pkt_count(cnt2));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit cmpEn = 0, rndMode = 0, useTab = 0, prevBusy = 0;
    int vprob = 100;
    int pend[N], len[N], beat[N], seq[N], fixL[N];
    logic [N-1:0] mute = '0, accMask = '0, eRdy;
    logic [31:0] tab [5] = '{32'h000C0014, 32'h00000001, 32'h01234562, 32'h01234563, 32'h01234564};
    logic [31:0] rxQ[$];
    logic lastQ[$];
    int grantQ[$];
    bit mBusy, mErr;
    int mGrant, mLastG, mStall;
    int mCnt[N];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: packet-atomic round robin by modular search from the last finished source
    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            mBusy = 0; mGrant = 0; mLastG = N - 1; mStall = 0; mErr = 0; accMask = '0;
            foreach (mCnt[i]) mCnt[i] = 0;
        end else begin
            accMask = '0;
            if (mBusy) begin
                if (srcVal[mGrant] && dataInReady) begin
                    accMask[mGrant] = 1'b1;
                    if (srcLast[mGrant]) begin
                        mBusy = 0;
                        mLastG = mGrant;
                        mCnt[mGrant] = (mCnt[mGrant] + 1) % (1 << CW);
                    end
                end
                if (clearErr) begin mStall = 0; mErr = 0; end
                else if (!srcVal[mGrant]) begin
                    mStall = (mStall + 1 > LIM) ? LIM : mStall + 1;
                    if (mStall == LIM) mErr = 1;
                end else mStall = 0;
            end else begin
                bit won;
                won = 0;
                if (clearErr) begin mStall = 0; mErr = 0; end
                for (int k = 1; k <= N; k++) begin
                    if (!won && srcVal[(mLastG + k) % N]) begin
                        won = 1;
                        mGrant = (mLastG + k) % N;
                        mBusy = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            eRdy = '0;
            if (mBusy && dataInReady) eRdy[mGrant] = 1'b1;
            chk("dataIn_val", dataInVal, mBusy && srcVal[mGrant]);
            chk("dataIn", dataIn, mBusy ? srcData[32*mGrant +: 32] : 32'h0);
            chk("dataIN_last", dataInLast, mBusy && srcLast[mGrant]);
            chk("src_ready", srcReady, eRdy);
            chk("grant_id", grantId, mGrant);
            chk("busy", busy, mBusy);
            chk("stall_err", stallErr, mErr);
            for (int i = 0; i < N; i++) chk("pkt_count", pktCount[CW*i +: CW], mCnt[i]);
        end
        if (dataInVal && dataInReady) begin
            rxQ.push_back(dataIn);
            lastQ.push_back(dataInLast);
        end
        if (busy && !prevBusy) grantQ.push_back(int'(grantId));
        prevBusy = busy;
    end

    function automatic int pendSum();
        int s = 0;
        foreach (pend[i]) s += pend[i];
        return s;
    endfunction

    task automatic present();
        for (int i = 0; i < N; i++) begin
            srcVal[i] = pend[i] > 0 && !mute[i] && ($urandom_range(99) < vprob);
            srcLast[i] = (beat[i] == len[i] - 1);
            srcData[32*i +: 32] = (useTab && i == 0) ? tab[beat[i]] : {8'(i), 8'(seq[i]), 16'(beat[i])};
        end
    endtask

    task automatic advance();
        for (int i = 0; i < N; i++) begin
            if (accMask[i]) begin
                beat[i]++;
                if (beat[i] == len[i]) begin
                    beat[i] = 0;
                    pend[i]--;
                    seq[i]++;
                    len[i] = fixL[i] != 0 ? fixL[i] : int'($urandom_range(1, 5));
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        advance();
        if (rndMode) begin
            dataInReady = ($urandom_range(3) != 0);
            clearErr = ($urandom_range(49) == 0);
        end
        present();
    endtask

    task automatic start(int i, int n, int l);
        pend[i] = n;
        fixL[i] = l;
        len[i] = l != 0 ? l : int'($urandom_range(1, 5));
        beat[i] = 0;
    endtask

    task automatic runIdle(int budget, string name);
        int n = 0;
        while ((pendSum() > 0 || busy) && n < budget) begin
            cyc();
            n++;
        end
        chk(name, n < budget, 1);
    endtask

    task automatic doReset();
        reset_b = 1'b0;
        foreach (pend[i]) begin pend[i] = 0; beat[i] = 0; seq[i] = 0; len[i] = 1; fixL[i] = 0; end
        mute = '0; clearErr = 0; dataInReady = 1; useTab = 0; vprob = 100; rndMode = 0;
        present();
        repeat (2) @(posedge clk);
        #1 reset_b = 1'b1;
        cmpEn = 1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grantId, 0);
        chk("rst_val", dataInVal, 0);
        chk("rst_rdy", srcReady, 0);
        chk("rst_err", stallErr, 0);
        chk("rst_cnt", pktCount, 0);
        rxQ.delete(); lastQ.delete(); grantQ.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] busyHist;
        int n;
        int exp2[5] = '{1, 2, 3, 0, 1};
        int npk[N];

        // single 5-beat packet from source 0
        doReset();
        useTab = 1;
        start(0, 1, 5);
        present();
        busyHist = '0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            busyHist[c] = busy;
        end
        chk("t1_busy_hist", busyHist, 8'h1F);
        chk("t1_nbeats", rxQ.size(), 5);
        for (int k = 0; k < 5 && k < rxQ.size(); k++) begin
            chk("t1_word", rxQ[k], tab[k]);
            chk("t1_last", lastQ[k], k == 4);
        end
        chk("t1_cnt0", pktCount[CW-1:0], 1);
        chk("t1_grant", grantId, 0);

        // three continuous requesters, 3-beat packets
        doReset();
        for (int i = 0; i < 3; i++) start(i, 2, 3);
        present();
        runIdle(200, "t2_timeout");
        chk("t2_npkts", grantQ.size(), 6);
        for (int j = 0; j < 6 && j < grantQ.size(); j++) chk("t2_order", grantQ[j], j % 3);
        for (int k = 0; k < 18 && k < rxQ.size() && k / 3 < grantQ.size(); k++)
            chk("t2_contig", rxQ[k][31:24], grantQ[k/3]);
        for (int i = 0; i < 3; i++) chk("t2_cnt", pktCount[CW*i +: CW], 2);

        // parser backpressure on a 4-beat packet from source 3
        doReset();
        dataInReady = 0;
        start(3, 1, 4);
        present();
        n = 0;
        while ((pendSum() > 0 || busy) && n < 40) begin
            cyc();
            if (busy) chk("t3_ready_mirror", srcReady[3], dataInReady);
            dataInReady = !dataInReady;
            n++;
        end
        dataInReady = 1;
        chk("t3_timeout", n < 40, 1);
        chk("t3_nbeats", rxQ.size(), 4);
        for (int k = 0; k < 4 && k < rxQ.size(); k++) chk("t3_word", rxQ[k], {8'd3, 8'd0, 16'(k)});
        chk("t3_err", stallErr, 0);
        chk("t3_cnt3", pktCount[CW*3 +: CW], 1);

        // source 1 stalls mid-packet for STALL_LIMIT cycles
        doReset();
        start(1, 1, 4);
        present();
        n = 0;
        while (beat[1] < 2 && n < 50) begin cyc(); n++; end
        chk("t4_reach", n < 50, 1);
        mute[1] = 1;
        present();
        for (int c = 1; c <= LIM; c++) begin
            cyc();
            if (c == LIM - 1) chk("t4_err_early", stallErr, 0);
            if (c == LIM) begin
                chk("t4_err_set", stallErr, 1);
                chk("t4_busy", busy, 1);
                chk("t4_grant", grantId, 1);
            end
        end
        mute[1] = 0;
        present();
        runIdle(50, "t4_timeout");
        chk("t4_cnt1", pktCount[CW +: CW], 1);
        chk("t4_sticky", stallErr, 1);
        clearErr = 1;
        cyc();
        chk("t4_cleared", stallErr, 0);
        clearErr = 0;

        // reset mid-packet
        doReset();
        start(0, 1, 1);
        present();
        runIdle(20, "t5_pre_timeout");
        chk("t5_pre_cnt0", pktCount[CW-1:0], 1);
        start(2, 1, 4);
        present();
        n = 0;
        while (beat[2] < 1 && n < 20) begin cyc(); n++; end
        #2 reset_b = 1'b0;
        #1;
        chk("t5_val", dataInVal, 0);
        chk("t5_busy", busy, 0);
        chk("t5_rdy", srcReady, 0);
        chk("t5_cnt", pktCount, 0);
        @(posedge clk);
        #1;
        foreach (beat[i]) beat[i] = 0;
        start(0, 1, 2);
        reset_b = 1'b1;
        grantQ.delete();
        present();
        runIdle(50, "t5_timeout");
        chk("t5_first", grantQ.size() > 0 ? grantQ[0] : 7, 0);
        chk("t5_second", grantQ.size() > 1 ? grantQ[1] : 7, 2);
        chk("t5_cnt2", pktCount[CW*2 +: CW], 1);

        // randomized traffic, ready and clear_err
        doReset();
        vprob = 70;
        rndMode = 1;
        for (int i = 0; i < N; i++) begin
            npk[i] = int'($urandom_range(3, 6));
            start(i, npk[i], 0);
        end
        present();
        runIdle(3000, "t6_timeout");
        rndMode = 0;
        dataInReady = 1;
        clearErr = 0;
        for (int i = 0; i < N; i++) chk("t6_cnt", pktCount[CW*i +: CW], npk[i]);

        // 2-source, 2-bit counters: single-beat packets wrap
        doReset();
        src2Val = 2'b01;
        src2Last = 2'b01;
        src2Data = 64'h0000_0000_DEAD_BEEF;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            chk("t7_busy", busy2, c % 2);
            if (c % 2 == 0) chk("t7_cnt", cnt2[1:0], exp2[c/2-1]);
        end
        src2Val = 2'b00;
        @(posedge clk);
        #1;
        chk("t7_idle", busy2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
